mmio_memory_ctrl: RTL and testbench
===================================

MMIO_MEMORY_CTRL -- requirements
Module: mmio_memory_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, word address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 4096, RAM words; legal range 1..2^ADDR_WIDTH-32.
REQ-004 SHALL have parameter NUM_DIGITS, default 4, seven-segment digits; legal range 1..4.
REQ-005 SHALL have parameter NUM_SW, default 12, switch inputs; legal range 1..16.
REQ-006 SHALL have parameter SCAN_BITS, default 19, display scan counter width.
REQ-007 SHALL have parameter DB_CYCLES, default 16, debounce stability count.
REQ-008 Port list: clk in 1, the single clock; reset in 1, asynchronous active-high reset.
REQ-009 req in 1, access request; wr in 1, 1 = write, 0 = read.
REQ-010 address in ADDR_WIDTH, word address; wdata in DATA_WIDTH, write data.
REQ-011 rdata out DATA_WIDTH, read data; ack out 1, access complete; err out 1, access out of range.
REQ-012 sw in NUM_SW, asynchronous switches; seg out 7, active-low cathodes a..g; an out NUM_DIGITS, active-low anodes; dp out 1, decimal point.

Function
REQ-013 FSM states: IDLE, BUSY, DONE. IDLE->BUSY when req=1; BUSY->DONE unconditionally; DONE->IDLE unconditionally.
REQ-014 address, wr and wdata SHALL be captured on the IDLE->BUSY edge; req is ignored in BUSY and DONE.
REQ-015 ack SHALL be high exactly one cycle, in DONE; access latency is 2 cycles from the req sample edge to ack.
REQ-016 rdata SHALL be valid while ack=1 for reads, and held until the next read completes; writes leave rdata unchanged.
REQ-017 Digit register i, 0 <= i < NUM_DIGITS, SHALL map to address 'hFFF0+4*i; a write stores wdata[3:0]; a read returns it zero-extended.
REQ-018 Switch nibble j SHALL map to address 'hFFE0+4*j, for j < ceil(NUM_SW/4); a read returns the conditioned switches [4j+3:4j], zero-padded; writes are ignored with err=0.
REQ-019 Other addresses below MEM_DEPTH SHALL access RAM; a RAM write commits in BUSY.
REQ-020 Any other address SHALL read 0 and drop writes; err=1 together with ack for that access, otherwise err=0.
REQ-021 Switches SHALL pass through a 2-flop synchroniser before any use.
REQ-022 The scan counter SHALL be SCAN_BITS wide, increment every clk and wrap to 0.
REQ-023 The active digit SHALL be the counter's top 2 bits modulo NUM_DIGITS; the matching an bit is 0 and all other bits are 1.
REQ-024 seg SHALL be the active-low hex decode (0-F) of the active digit register; dp SHALL be constant 1.
REQ-025 A digit write SHALL reach seg within one clk after ack, without waiting for the scan.

Reset
REQ-026 reset=1 SHALL force, asynchronously: state IDLE, ack=0, err=0, rdata=0, digits=0, scan counter=0, synchroniser and debounce registers=0.
REQ-027 Reset SHALL leave RAM contents unchanged.
REQ-028 Reset asserted in BUSY SHALL abort the access with no ack and no RAM write.
REQ-029 After reset, an SHALL be 0 at index 0 and 1 elsewhere, and seg SHALL show 0.

Configuration
REQ-030 Macro MMIO_SW_DEBOUNCE_EN defined: each synchronised switch bit SHALL update its conditioned value only after DB_CYCLES consecutive equal samples; each bit has its own counter, and the counter restarts on any change.
REQ-031 Macro MMIO_SW_DEBOUNCE_EN undefined: conditioned value SHALL equal the synchroniser output; DB_CYCLES is unused.

Verification
REQ-032 Write 'hDEADBEEF to 'h0010, then read 'h0010 -> ack 2 cycles after each req; rdata='hDEADBEEF, err=0.
REQ-033 Write 'h0000000A to 'hFFFC, NUM_DIGITS=4 -> read returns 'hA; seg=7'b0001000 whenever an=4'b0111.
REQ-034 sw=12'hA53, without the macro -> read 'hFFE4 returns 'h5 after 2 sync cycles; read 'hFFE8 returns 'hA.
REQ-035 Read MEM_DEPTH+1 (non-I/O), and write to it -> rdata=0, err=1 with ack; RAM unchanged.
REQ-036 Assert reset in BUSY of a write to 'h0020 -> no ack; read of 'h0020 returns its old value; digits read 0.
REQ-037 With the macro, DB_CYCLES=16, toggle sw[0] for 10 cycles, then hold 1 for 16 cycles -> read 'hFFE0 bit0=0 during the toggling, and 1 only after the 16 stable cycles.

Source files
------------

// File: rtl/mmio_memory_ctrl.sv
// Memory-mapped controller: word RAM, seven-segment digit registers and switch inputs behind a 3-state access FSM.
// Optional macro MMIO_SW_DEBOUNCE_EN adds a per-bit debounce stage after the switch synchroniser.
module mmio_memory_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 4096,
  parameter int NUM_DIGITS = 4,
  parameter int NUM_SW     = 12,
  parameter int SCAN_BITS  = 19,
  parameter int DB_CYCLES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  err,
  input  logic [NUM_SW-1:0]     sw,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp
);

  localparam int RamAw  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int NumNib = (NUM_SW + 3) / 4;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 4 || NUM_SW < 1 || NUM_SW > 16 ||
      MEM_DEPTH < 1 || SCAN_BITS < 2 || DB_CYCLES < 1) begin : g_param_err
    $error("mmio_memory_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [3:0]            digit_q [NUM_DIGITS];

  logic             is_digit, is_sw, is_ram;
  logic [1:0]       digit_idx, sw_idx;
  logic [RamAw-1:0] ram_idx;
  logic [DATA_WIDTH-1:0] rd_val;

  logic [NUM_SW-1:0] sync1_q, sync2_q, sw_cond;
  logic [15:0]       sw_pad;
  logic [SCAN_BITS-1:0] scan_q;
  logic [1:0]        active;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack = 1'b0;
    err = 1'b0;
    if (state == DONE) begin
      ack = 1'b1;
      err = err_q;
    end
  end

  assign rdata = rdata_q;
  assign dp    = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      addr_q  <= address;
      wr_q    <= wr;
      wdata_q <= wdata;
    end
  end

  // I/O windows take priority; RAM covers whatever else lies below MEM_DEPTH.
  always_comb begin
    is_digit  = 1'b0;
    digit_idx = '0;
    is_sw     = 1'b0;
    sw_idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (addr_q == ADDR_WIDTH'(32'hFFF0 + 32'(4 * i))) begin
        is_digit  = 1'b1;
        digit_idx = 2'(i);
      end
    end
    for (int j = 0; j < NumNib; j++) begin
      if (addr_q == ADDR_WIDTH'(32'hFFE0 + 32'(4 * j))) begin
        is_sw  = 1'b1;
        sw_idx = 2'(j);
      end
    end
    is_ram  = !is_digit && !is_sw && (32'(addr_q) < 32'(MEM_DEPTH));
    ram_idx = addr_q[RamAw-1:0];
  end

  always_comb begin
    rd_val = '0;
    if (is_digit)    rd_val = DATA_WIDTH'(digit_q[digit_idx]);
    else if (is_sw)  rd_val = DATA_WIDTH'(sw_pad[{sw_idx, 2'b00} +: 4]);
    else if (is_ram) rd_val = mem[ram_idx];
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM and survives reset.
  always_ff @(posedge clk) begin
    if (state == BUSY && wr_q && is_ram) mem[ram_idx] <= wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'h0;
    end else if (state == BUSY) begin
      err_q <= !(is_digit || is_sw || is_ram);
      if (!wr_q) rdata_q <= rd_val;
      else if (is_digit) digit_q[digit_idx] <= wdata_q[3:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

`ifdef MMIO_SW_DEBOUNCE_EN
  localparam int DbW = $clog2(DB_CYCLES + 1);
  logic [DbW-1:0]    db_cnt [NUM_SW];
  logic [NUM_SW-1:0] db_q;

  // A sample equal to the held value restarts the count; DB_CYCLES differing samples in a row commit it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q <= '0;
      for (int b = 0; b < NUM_SW; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_SW; b++) begin
        if (sync2_q[b] == db_q[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DbW'(DB_CYCLES - 1)) begin
          db_q[b]   <= sync2_q[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end
  assign sw_cond = db_q;
`else
  assign sw_cond = sync2_q;
`endif

  assign sw_pad = 16'(sw_cond);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) scan_q <= '0;
    else       scan_q <= scan_q + 1'b1;
  end

  assign active = 2'(int'(scan_q[SCAN_BITS-1 -: 2]) % NUM_DIGITS);
  assign an     = ~(NUM_DIGITS'(1) << active);

  // seg = {a,b,c,d,e,f,g}, active-low; decodes the live register so writes show immediately.
  always_comb begin
    seg = 7'b1111111;
    case (digit_q[active])
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_mmio_memory_ctrl.sv
// Directed, table-driven bench for mmio_memory_ctrl; short scan counter so every digit is visited quickly.
module tb_mmio_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [15:0] address;
  logic [31:0] wdata, rdata;
  logic        ack, err;
  logic [11:0] sw;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_memory_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(4096), .NUM_DIGITS(4),
    .NUM_SW(12), .SCAN_BITS(6), .DB_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .address(address),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .sw(sw),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus access; lat counts clock edges from the req sample edge to the first ack.
  task automatic access(input logic w, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    @(posedge clk); #1;
    req = 1'b1; wr = w; address = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!ack && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    e  = err;
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] rd;
  logic        e;
  int          lat;
  logic [6:0]  exp_seg;
  logic [3:0]  prev_an;
  int          guard;

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; address = '0; wdata = '0; sw = 12'hA53;

    vecs.push_back('{1'b1, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 16'h0020, 32'h12345678, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 16'h0020, 32'h0,        32'h12345678, 1'b0});
    vecs.push_back('{1'b1, 16'h0001, 32'h11111111, 32'h12345678, 1'b0});
    vecs.push_back('{1'b1, 16'h0FFF, 32'hCAFEF00D, 32'h12345678, 1'b0});
    vecs.push_back('{1'b0, 16'h0FFF, 32'h0,        32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b0, 16'h1001, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 16'h1001, 32'h55555555, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 16'h0001, 32'h0,        32'h11111111, 1'b0});
    vecs.push_back('{1'b0, 16'h1000, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 16'hFFFC, 32'h0000000A, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 16'hFFFC, 32'h0,        32'h0000000A, 1'b0});
    vecs.push_back('{1'b1, 16'hFFF0, 32'h00000FF3, 32'h0000000A, 1'b0});
    vecs.push_back('{1'b0, 16'hFFF0, 32'h0,        32'h00000003, 1'b0});
    vecs.push_back('{1'b0, 16'hFFF4, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 16'hFFE0, 32'h0,        32'h00000003, 1'b0});
    vecs.push_back('{1'b0, 16'hFFE4, 32'h0,        32'h00000005, 1'b0});
    vecs.push_back('{1'b0, 16'hFFE8, 32'h0,        32'h0000000A, 1'b0});
    vecs.push_back('{1'b1, 16'hFFE4, 32'hFFFFFFFF, 32'h0000000A, 1'b0});
    vecs.push_back('{1'b0, 16'hFFE4, 32'h0,        32'h00000005, 1'b0});
    vecs.push_back('{1'b0, 16'hFFEC, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 16'hFFF1, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 16'hFFF8, 32'h0,        32'h00000000, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack",   32'(ack),   32'h0);
    check("reset_err",   32'(err),   32'h0);
    check("reset_rdata", rdata,      32'h0);
    check("reset_an",    32'(an),    32'hE);
    check("reset_seg",   32'(seg),   32'h01);
    check("reset_dp",    32'(dp),    32'h1);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Vector table
    foreach (vecs[k]) begin
      access(vecs[k].w, vecs[k].a, vecs[k].d, rd, e, lat);
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'd2);
      check($sformatf("vec%0d_rdata", k),   rd,       vecs[k].exp_rd);
      check($sformatf("vec%0d_err", k),     32'(e),   32'(vecs[k].exp_err));
    end

    // ack is a single-cycle pulse
    access(1'b0, 16'h0010, 32'h0, rd, e, lat);
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(ack), 32'h0);
    check("rdata_held",    rdata,    32'hDEADBEEF);

    // Scan: digit0=3, digit1=0, digit2=0, digit3=A
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      case (an)
        4'b1110: exp_seg = 7'b0000110;
        4'b1101: exp_seg = 7'b0000001;
        4'b1011: exp_seg = 7'b0000001;
        4'b0111: exp_seg = 7'b0001000;
        default: exp_seg = 7'b1111111;
      endcase
      if (exp_seg == 7'b1111111) check("scan_an_onehot", 32'(an), 32'hE);
      else check($sformatf("scan_seg_an%b", an), 32'(seg), 32'(exp_seg));
    end

    // Digit write shows on seg one clock after ack, inside the same scan slot
    prev_an = an;
    guard = 0;
    while (!(an == 4'b1110 && prev_an != 4'b1110) && guard < 100) begin
      prev_an = an;
      @(posedge clk); #1;
      guard++;
    end
    check("scan_slot_found", 32'(guard < 100), 32'h1);
    access(1'b1, 16'hFFF0, 32'h00000008, rd, e, lat);
    @(posedge clk); #1;
    check("fast_seg_an",  32'(an),  32'hE);
    check("fast_seg_val", 32'(seg), 32'h00);

    // Reset during BUSY of a write aborts it
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; address = 16'h0020; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_ack_async", 32'(ack), 32'h0);
    @(posedge clk); #1;
    check("abort_ack",   32'(ack), 32'h0);
    check("abort_rdata", rdata,    32'h0);
    check("abort_an",    32'(an),  32'hE);
    check("abort_seg",   32'(seg), 32'h01);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_no_late_ack", 32'(ack), 32'h0);
    access(1'b0, 16'h0020, 32'h0, rd, e, lat);
    check("abort_ram_old", rd, 32'h12345678);
    access(1'b0, 16'hFFF0, 32'h0, rd, e, lat);
    check("abort_digit0", rd, 32'h0);
    access(1'b0, 16'hFFFC, 32'h0, rd, e, lat);
    check("abort_digit3", rd, 32'h0);

`ifdef MMIO_SW_DEBOUNCE_EN
    // Debounce: bit0 held low, then chattering, then stable high
    sw = 12'hA52;
    repeat (25) @(posedge clk);
    fork
      begin
        for (int t = 0; t < 10; t++) begin
          @(posedge clk); #2;
          sw[0] = ~sw[0];
        end
      end
      begin
        access(1'b0, 16'hFFE0, 32'h0, rd, e, lat);
        check("db_toggling", rd, 32'h2);
      end
    join
    sw[0] = 1'b1;
    repeat (10) @(posedge clk);
    access(1'b0, 16'hFFE0, 32'h0, rd, e, lat);
    check("db_not_yet", rd, 32'h2);
    repeat (12) @(posedge clk);
    access(1'b0, 16'hFFE0, 32'h0, rd, e, lat);
    check("db_settled", rd, 32'h3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
